mmio_timer: RTL
===============

# mmio_timer

Memory-mapped down-counting timer that responds on the processor's data-memory port: same ce/we/addr/sel/data signalling as the data RAM, in the same single-cycle system. The top level routes a 16-byte address window to it. Software can program a reload value, start or stop counting, poll or clear an expiry flag, and receive a level interrupt. Reads are combinational because the core completes a load in the same cycle. Writes commit on the clock edge.

## Interface
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 16-byte register window; addr[31:4] must equal BASE_ADDR[31:4].
- PRESCALE, 1, clock cycles per counter tick; legal range 1..65536.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- ce  input  1  access enable from the core's data port.
- we  input  1  1 = write, 0 = read; meaningful only when ce=1.
- addr  input  32  byte address; addr[3:2] selects the register, addr[1:0] ignored.
- sel  input  4  byte enables; sel[3] covers data_i[31:24] and sel[0] covers data_i[7:0].
- data_i  input  32  write data.
- data_o  output  32  read data, combinational.
- irq  output  1  level interrupt, high while STATUS.EXPIRED=1 and CTRL.IRQ_EN=1.

## Operation
- A hit requires ce=1 and a match on addr[31:4]. Accesses that are not hits have no effect, and data_o=0 for them.
- Registers, selected by addr[3:2]:
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Bits [31:3] read 0 and are not writable.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: 32-bit down-counter. A write to COUNT overwrites the counter.
  - 3 STATUS: bit0 EXPIRED; writing 1 to bit0 clears it (W1C). All other bits read 0.
- Writes are byte-masked by sel. For COUNT and LOAD, unselected bytes keep their old value. For STATUS, W1C applies only when sel[0]=1.
- Prescaler: counts 0..PRESCALE-1 while EN=1 and asserts tick on PRESCALE-1. It clears to 0 when EN=0 or when COUNT is written.
- On tick with EN=1:
  - COUNT≠0 → COUNT−1.
  - COUNT=0 → EXPIRED←1. If AUTO_RELOAD=1, COUNT←LOAD; otherwise COUNT stays 0 and EN←0.
  - Result: one expiry every (LOAD+1)×PRESCALE cycles.
- Simultaneous events:
  - A COUNT write beats decrement or reload in the same cycle.
  - A CTRL write beats the hardware clear of EN.
  - A hardware EXPIRED set beats a W1C clear in the same cycle.
- Read data: data_o returns the register's pre-edge value. sel is ignored on reads; the full word is returned.

## Timing
- Reset (rst=0 at the edge): CTRL=0, LOAD=0, COUNT=0, STATUS=0, prescaler=0. Outputs after reset: irq=0; data_o=0 unless a read hit is driven.
- Reset applies mid-count and overrides any write in the same cycle.
- Write latency is 1 edge. With PRESCALE=1 the first decrement happens on the edge after the edge that wrote EN=1.
- irq follows the registered state combinationally. It rises in the same cycle that EXPIRED becomes 1 and falls the cycle after an effective W1C or an IRQ_EN clear.
- No wait states and no handshake: every hit completes in one cycle.

## Structure
- A shared package holds:
  - register offsets: CTRL=2'd0, LOAD=2'd1, COUNT=2'd2, STATUS=2'd3;
  - CTRL bit indices;
  - the 32-bit word width, matching the existing register-bus width define.
- A natural sub-module is mmio_prescaler: a parameterized PRESCALE counter with enable/clear inputs and a tick output.
- The register file, counter logic and read mux stay in mmio_timer.

## Test plan
- Reset and readback:
  - Stimulus: hold rst=0 for 2 cycles, then read all 4 offsets.
  - Required: all read 0 and irq=0. A read at BASE_ADDR+16 returns 0, and a write there changes nothing.
- One-shot, PRESCALE=1:
  - Stimulus: write COUNT=3, then CTRL=0x5.
  - Required: COUNT reads 2, 1, 0 on consecutive cycles; EXPIRED=1 and irq=1 on the 4th tick; EN reads 0; COUNT stays 0.
- Auto-reload, PRESCALE=4:
  - Stimulus: LOAD=2, COUNT=2, CTRL=0x3.
  - Required: expiry every 12 cycles; COUNT reloads to 2.
- Byte-masked write:
  - Stimulus: LOAD=0xAABBCCDD, then a write of 0x11223344 with sel=4'b0101.
  - Required: LOAD reads 0xAA22CC44.
- Collision cases:
  - A W1C to STATUS on the same edge as expiry → EXPIRED stays 1.
  - A COUNT=7 write on the same edge as a decrement → COUNT reads 7.
- Reset mid-count:
  - Stimulus: COUNT=100 with EN=1; assert rst=0 at count 50.
  - Required: all registers are 0 next cycle and irq=0.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: word width,
// register offsets, CTRL/STATUS bit positions and the byte-lane merge helper.
package mmio_timer_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_LOAD   = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_off_e;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int STATUS_EXPIRED   = 0;

  // Bytes whose sel bit is low keep their previous contents.
  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_word,
                                                   input logic [WORD_W-1:0] new_word,
                                                   input logic [3:0]        sel);
    logic [WORD_W-1:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = sel[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Data-memory port signalling (ce/we/addr/sel/data) shared by the core and the timer.
// Single-cycle bus: a hit (ce=1, address in window) completes in the cycle it is
// presented; reads return data_o combinationally, writes commit on the next clk edge.
interface mmio_timer_if;
  import mmio_timer_pkg::*;

  logic              ce;
  logic              we;
  logic [31:0]       addr;
  logic [3:0]        sel;
  logic [WORD_W-1:0] data_i;
  logic [WORD_W-1:0] data_o;

  modport master (output ce, we, addr, sel, data_i, input data_o);
  modport slave  (input ce, we, addr, sel, data_i, output data_o);

endinterface

// File: rtl/mmio_prescaler.sv
// Cycle divider: counts 0..PRESCALE-1 while enabled and flags tick on the last count.
// Held at 0 while disabled or when clr is asserted.
module mmio_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst || !en || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with reload, one-shot/auto-reload modes,
// a W1C expiry flag and a level interrupt. Reads are combinational.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          PRESCALE  = 1
) (
  input  logic            clk,
  input  logic            rst,
  mmio_timer_if.slave     bus,
  output logic            irq
);

  logic [2:0]        ctrl_q;
  logic [WORD_W-1:0] load_q;
  logic [WORD_W-1:0] count_q;
  logic              expired_q;

  logic              hit;
  reg_off_e          off;
  logic              wr_ctrl, wr_load, wr_count, wr_status;
  logic              tick, step, expire;
  logic [WORD_W-1:0] rdata;
  logic              unused_addr_lsbs;

  assign hit       = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off       = reg_off_e'(bus.addr[3:2]);
  assign wr_ctrl   = hit && bus.we && (off == REG_CTRL);
  assign wr_load   = hit && bus.we && (off == REG_LOAD);
  assign wr_count  = hit && bus.we && (off == REG_COUNT);
  assign wr_status = hit && bus.we && (off == REG_STATUS);
  assign unused_addr_lsbs = ^bus.addr[1:0];

  mmio_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_q[CTRL_EN]),
    .clr  (wr_count),
    .tick (tick)
  );

  assign step   = tick && ctrl_q[CTRL_EN];
  assign expire = step && (count_q == '0);

  // Priority on a shared edge: software COUNT/CTRL writes win over hardware
  // updates, while a hardware expiry wins over a software W1C.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        if (bus.sel[0]) ctrl_q <= bus.data_i[2:0];
      end else if (expire && !ctrl_q[CTRL_AUTO_RELOAD]) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end

      if (wr_load) load_q <= byte_merge(load_q, bus.data_i, bus.sel);

      if (wr_count) begin
        count_q <= byte_merge(count_q, bus.data_i, bus.sel);
      end else if (step) begin
        if (count_q != '0)                  count_q <= count_q - 1'b1;
        else if (ctrl_q[CTRL_AUTO_RELOAD])  count_q <= load_q;
      end

      if (expire) begin
        expired_q <= 1'b1;
      end else if (wr_status && bus.sel[0] && bus.data_i[STATUS_EXPIRED]) begin
        expired_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (hit && !bus.we) begin
      case (off)
        REG_CTRL:   rdata = {{(WORD_W-3){1'b0}}, ctrl_q};
        REG_LOAD:   rdata = load_q;
        REG_COUNT:  rdata = count_q;
        REG_STATUS: rdata = {{(WORD_W-1){1'b0}}, expired_q};
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.data_o = rdata;
  assign irq        = expired_q && ctrl_q[CTRL_IRQ_EN];

endmodule
